// File: rtl/controle_acumulador.sv
// rtl/controle_acumulador.sv - accumulator control around an external 4-bit adder
// Feeds operands to the adder, registers the sum, and emits a result every N_OPERANDOS accepts.
module controle_acumulador #(
  parameter int N_OPERANDOS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       limpar,
  input  logic       modo_sub,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic [3:0] soma_a,
  output logic [3:0] soma_b,
  output logic       soma_cin,
  input  logic [3:0] soma_s,
  input  logic       soma_cout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic       out_carry
);

  typedef enum logic {ACUMULA, SAIDA} estado_t;

  localparam logic [3:0] ULTIMO = 4'(N_OPERANDOS - 1);

  estado_t    estado, estado_prox;
  logic [3:0] acc;
  logic [3:0] cnt;
  logic       flag;
  logic       aceita;
  logic       entrega;
  logic       pronto;

  // Subtraction is acc + ~in_data + 1 through the same adder.
  assign soma_a   = acc;
  assign soma_b   = modo_sub ? ~in_data : in_data;
  assign soma_cin = modo_sub;

  assign out_data  = (estado == SAIDA) ? acc  : 4'h0;
  assign out_carry = (estado == SAIDA) ? flag : 1'b0;
  assign in_ready  = pronto;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= ACUMULA;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    pronto      = 1'b0;
    out_valid   = 1'b0;
    aceita      = 1'b0;
    entrega     = 1'b0;
    case (estado)
      ACUMULA: begin
        pronto = rst_n & ~limpar;
        aceita = in_valid & rst_n & ~limpar;
        if (aceita && cnt == ULTIMO) begin
          estado_prox = SAIDA;
        end
      end
      SAIDA: begin
        out_valid = 1'b1;
        entrega   = out_ready & ~limpar;
        if (entrega) begin
          estado_prox = ACUMULA;
        end
      end
      default: estado_prox = ACUMULA;
    endcase
    if (limpar) begin
      estado_prox = ACUMULA;
    end
  end

  // A carry on add or a missing carry on subtract marks overflow/borrow; the flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= 4'h0;
      cnt  <= 4'h0;
      flag <= 1'b0;
    end else if (limpar || entrega) begin
      acc  <= 4'h0;
      cnt  <= 4'h0;
      flag <= 1'b0;
    end else if (aceita) begin
      acc  <= soma_s;
      cnt  <= cnt + 4'h1;
      flag <= flag | (modo_sub ? ~soma_cout : soma_cout);
    end
  end

endmodule
